// File: rtl/rv_pkg.sv
// Shared RV32 fetch-side types and constants: NOP encoding, major opcodes, fetch FSM states.
// No logic here; latency and backpressure are properties of the modules that import it.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

    localparam logic [6:0] OPC_JAL    = 7'b110_1111;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_OPIMM  = 7'b001_0011;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_ent_t;

endpackage

// File: rtl/if_fifo.sv
// Generic synchronous FIFO with clear; head is read combinationally (0-cycle read latency).
// Backpressure: caller must not push when full unless popping in the same cycle.
module if_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    input  logic                   clear,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assert property (@(posedge clk) disable iff (reset) !(push && full && !pop && !clear));

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, imem request/response tracking, instruction buffer to decode; IF_PERF_CNT_EN adds perf counters.
// Latency: imem latency + 1 cycle to id_valid; backpressure: id_ready low fills the buffer, then requests stop.
module if_stage
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          FIFO_DEPTH   = 2,
    parameter int          MAX_OUTST    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam int OW = $clog2(MAX_OUTST) + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTST);

    fetch_state_t  state;
    fetch_state_t  state_nxt;
    logic [31:0]   pc;
    logic [OW-1:0] outst;
    logic [OW-1:0] discard;
    logic [31:0]   occupancy;
    logic          req_fire;
    logic          rsp_keep;
    logic          id_pop;

    fetch_ent_t    push_ent;
    fetch_ent_t    head_ent;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;

    logic [31:0]   pc_tag;
    logic [OW-1:0] pcq_count;
    logic          pcq_empty;
    logic          pcq_full;

    // A slot freed by this cycle's pop is counted as free, giving 1 instr/cycle at latency 1.
    assign id_pop         = !fifo_empty && id_ready;
    assign occupancy      = 32'(outst) + 32'(fifo_count) - 32'(id_pop);
    assign imem_req_valid = (state == RUN) && (occupancy < 32'(FIFO_DEPTH))
                            && (outst < MAX_O) && !redir_valid;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && (discard == '0);
    assign imem_addr      = pc;

    assign push_ent = '{instr: imem_rsp_data, pc: pc_tag};
    assign id_valid = !fifo_empty;
    assign id_instr = fifo_empty ? RV_NOP : head_ent.instr;
    assign id_pc    = fifo_empty ? pc : head_ent.pc;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fetch_en) state_nxt = RUN;
            RUN:     if (!fetch_en) state_nxt = IDLE;
            FLUSH:   if (discard == '0) state_nxt = fetch_en ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (redir_valid && (outst != '0)) state_nxt = FLUSH;
    end

    // outst counts every in-flight request, including those already marked for discard.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= RESET_VECTOR;
            outst   <= '0;
            discard <= '0;
        end else begin
            state <= state_nxt;
            outst <= outst + OW'(req_fire) - OW'(imem_rsp_valid);
            if (redir_valid)
                discard <= outst - OW'(imem_rsp_valid);
            else if (imem_rsp_valid && (discard != '0))
                discard <= discard - OW'(1);
            if (redir_valid)
                pc <= redir_pc & ~32'h3;
            else if (req_fire)
                pc <= pc + 32'd4;
        end
    end

    if_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_ibuf (
        .clk   (clk),
        .reset (reset),
        .push  (rsp_keep),
        .wdata (push_ent),
        .pop   (id_pop),
        .clear (redir_valid),
        .rdata (head_ent),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    if_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTST)
    ) u_pcq (
        .clk   (clk),
        .reset (reset),
        .push  (req_fire),
        .wdata (pc),
        .pop   (rsp_keep),
        .clear (redir_valid),
        .rdata (pc_tag),
        .count (pcq_count),
        .empty (pcq_empty),
        .full  (pcq_full)
    );

    assert property (@(posedge clk) disable iff (reset) pcq_count == outst - discard);
    assert property (@(posedge clk) disable iff (reset) rsp_keep |-> !pcq_empty);
    assert property (@(posedge clk) disable iff (reset) req_fire |-> !pcq_full);
    assert property (@(posedge clk) disable iff (reset)
                     (rsp_keep && !redir_valid) |-> (!fifo_full || id_pop));

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (id_pop) perf_fetched <= perf_fetched + 32'd1;
            if ((state == RUN) && fifo_empty) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: imem model with variable in-order latency, decode-side stream model.
// Expected PC/instruction streams are derived from fetch/redirect rules, not from DUT state.
module tb_if_stage;
    import rv_pkg::*;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam int FD = 2;
    localparam int MO = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    always #5 clk = ~clk;

    if_stage #(.RESET_VECTOR(RV), .FIFO_DEPTH(FD), .MAX_OUTST(MO)) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redir_valid    (redir_valid),
        .redir_pc       (redir_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_due = 0;
    int lat_min = 1;
    int lat_max = 1;
    int rdy_pct = 100;
    int seg_reqs = 0;
    int seg_pops = 0;
    int n_pop = 0;
    bit chk_empty = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_req_pc;
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    // Memory content is a fixed function of the address, so any delivered word can be predicted.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [6:0] op;
        case (a[4:2])
            3'd0:    op = OPC_JAL;
            3'd1:    op = OPC_BRANCH;
            3'd2:    op = OPC_LOAD;
            3'd3:    op = OPC_STORE;
            default: op = OPC_OPIMM;
        endcase
        return {a[26:2] ^ 25'h1AB_CDEF, op};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mem_drive();
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_at(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = ($urandom_range(99) < rdy_pct);
    endtask

    task automatic cycle();
        bit fire;
        bit pop;
        int due;
        #1;
        fire = imem_req_valid && imem_req_ready;
        pop  = id_valid && id_ready;
        if (chk_empty) check("flush_empty", 32'(id_valid), 32'd0);
        chk_empty = 0;
`ifdef IF_PERF_CNT_EN
        check("perf_fetched", perf_fetched, 32'(n_pop));
`endif
        if (!id_valid) begin
            check("nop_when_empty", id_instr, RV_NOP);
        end else begin
            check("id_pc", id_pc, exp_pc);
            check("id_instr", id_instr, word_at(exp_pc));
        end
        if (imem_req_valid) begin
            check("req_addr", imem_addr, exp_req_pc);
            check("no_req_on_redir", 32'(redir_valid), 32'd0);
        end
        if (fire) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_addr.push_back(imem_addr);
            pend_due.push_back(due);
            exp_req_pc += 32'd4;
            seg_reqs++;
        end
        if (pop) begin
            exp_pc += 32'd4;
            seg_pops++;
            n_pop++;
        end
        check("outst_bound", 32'(pend_due.size() <= MO), 32'd1);
        check("buffer_bound", 32'((seg_reqs - seg_pops) <= FD), 32'd1);
        if (redir_valid) begin
            exp_pc     = redir_pc & ~32'h3;
            exp_req_pc = redir_pc & ~32'h3;
            seg_reqs   = 0;
            seg_pops   = 0;
            chk_empty  = 1;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        mem_drive();
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        fetch_en       = 1'b0;
        id_ready       = 1'b0;
        redir_valid    = 1'b0;
        redir_pc       = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_req_ready = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        #1;
        check("rst_async_req", 32'(imem_req_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id_instr", id_instr, RV_NOP);
        check("rst_id_pc", id_pc, RV);
        check("rst_imem_addr", imem_addr, RV);
`ifdef IF_PERF_CNT_EN
        check("rst_perf_fetched", perf_fetched, 32'd0);
        check("rst_perf_stall", perf_stall, 32'd0);
`endif
        reset      = 1'b0;
        exp_pc     = RV;
        exp_req_pc = RV;
        seg_reqs   = 0;
        seg_pops   = 0;
        n_pop      = 0;
        chk_empty  = 0;
        cyc++;
        last_due   = cyc;
        mem_drive();
    endtask

    task automatic run_until_valid(input string tag, input int max);
        for (int i = 0; i < max && !id_valid; i++) cycle();
        check(tag, 32'(id_valid), 32'd1);
    endtask

    task automatic run_until_two_outst(input string tag, input int max);
        for (int i = 0; i < max && pend_due.size() != 2; i++) cycle();
        check(tag, 32'(pend_due.size()), 32'd2);
    endtask

    initial begin
        do_reset();

        // 1: streaming at latency 1, one instruction per cycle
        fetch_en = 1'b1;
        id_ready = 1'b1;
        run_until_valid("t1_first_valid", 10);
        check("t1_first_pc", id_pc, RV);
        for (int i = 0; i < 8; i++) begin
            check("t1_no_bubble", 32'(id_valid), 32'd1);
            cycle();
        end

        // 2: decode stalls for 5 cycles
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        check("t2_held_valid", 32'(id_valid), 32'd1);
        check("t2_buffered", 32'(seg_reqs - seg_pops), 32'(FD));
        check("t2_no_req", 32'(imem_req_valid), 32'd0);
        id_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle();

        // 3: redirect with two requests in flight
        lat_min = 3;
        lat_max = 3;
        run_until_two_outst("t3_two_outst", 20);
        redir_valid = 1'b1;
        redir_pc    = 32'h0000_0100;
        cycle();
        redir_valid = 1'b0;
        run_until_valid("t3_wait_valid", 20);
        check("t3_target_pc", id_pc, 32'h0000_0100);

        // 4: misaligned redirect target
        lat_min = 1;
        lat_max = 1;
        redir_valid = 1'b1;
        redir_pc    = 32'h0000_0103;
        cycle();
        redir_valid = 1'b0;
        for (int i = 0; i < 10 && !imem_req_valid; i++) cycle();
        check("t4_req_seen", 32'(imem_req_valid), 32'd1);
        check("t4_aligned_addr", imem_addr, 32'h0000_0100);

        // 5: redirect coinciding with a pop and a response
        for (int i = 0; i < 20 && !(id_valid && imem_rsp_valid); i++) cycle();
        check("t5_cond", 32'({id_valid, imem_rsp_valid}), 32'd3);
        redir_valid = 1'b1;
        redir_pc    = 32'h0000_0200;
        cycle();
        redir_valid = 1'b0;
        run_until_valid("t5_wait_valid", 20);
        check("t5_target_pc", id_pc, 32'h0000_0200);

        // 6: reset with two requests in flight
        lat_min = 3;
        lat_max = 3;
        run_until_two_outst("t6_two_outst", 20);
        do_reset();

        // Randomized traffic
        lat_min  = 1;
        lat_max  = 3;
        rdy_pct  = 70;
        for (int i = 0; i < 2000; i++) begin
            fetch_en    = ($urandom_range(7) != 0);
            id_ready    = ($urandom_range(2) != 0);
            redir_valid = ($urandom_range(29) == 0);
            redir_pc    = $urandom;
            cycle();
        end
        redir_valid = 1'b0;
        fetch_en    = 1'b0;
        id_ready    = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
        check("drain_empty", 32'(id_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
